register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register-index width (2**ADDR_WIDTH registers).
REQ-003 Parameter SP_INIT, default 32'h7FFF_EFFC, SHALL set the reset value of x2 (sp).
REQ-004 Parameter GP_INIT, default 32'h1000_8000, SHALL set the reset value of x3 (gp).
REQ-005 clk  input  1  SHALL be the only clock; all state updates on the rising edge.
REQ-006 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 Reg_Write_i  input  1  SHALL be the write enable for the current cycle.
REQ-008 Write_Register_i  input  ADDR_WIDTH  SHALL be the destination register index (rd).
REQ-009 Read_Register_1_i  input  ADDR_WIDTH  SHALL be the first source index (rs1).
REQ-010 Read_Register_2_i  input  ADDR_WIDTH  SHALL be the second source index (rs2).
REQ-011 Write_Data_i  input  DATA_WIDTH  SHALL be the write-back value.
REQ-012 Read_Data_1_o  output  DATA_WIDTH  SHALL carry x[rs1], driving ALU operand A.
REQ-013 Read_Data_2_o  output  DATA_WIDTH  SHALL carry x[rs2], feeding the ALU operand-B mux.

Function
REQ-014 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits, x0..x31 at default size.
REQ-015 x0 SHALL read as 0 at all times; writes to index 0 SHALL be discarded.
REQ-016 Write: with Reg_Write_i=1 at a rising clk, x[Write_Register_i] SHALL load Write_Data_i; one write per cycle.
REQ-017 With Reg_Write_i=0, no register SHALL change.
REQ-018 Reads SHALL be combinational, zero latency: outputs follow index or content changes in the same cycle.
REQ-019 Both read ports SHALL be independent; rs1==rs2 SHALL return the same value on both.
REQ-020 Read and write to the same index in one cycle SHALL return the old value until the edge, then the new value (no write-through bypass).
REQ-021 Write data SHALL be stored unmodified; no sign handling or arithmetic.
REQ-022 X/undefined Write_Register_i with Reg_Write_i=0 SHALL NOT corrupt state.

Reset
REQ-023 reset low SHALL immediately, without a clk edge, set x2=SP_INIT, x3=GP_INIT and every other register to 0.
REQ-024 While reset is low, writes SHALL be ignored; read ports SHALL show reset values.
REQ-025 Reset deassertion SHALL take effect from the first rising clk with reset high; a write coinciding with deassertion SHALL be accepted only if reset is high at that edge.
REQ-026 Reset asserted mid-cycle SHALL override any pending write.

Structure
REQ-027 A shared package SHALL hold DATA_WIDTH, ADDR_WIDTH and ABI index constants (ZERO=0, RA=1, SP=2, GP=3) and the SP/GP reset values, shared with ALU, control and top level.
REQ-028 A single sub-module, data_register (DATA_WIDTH-wide, async active-low reset, enable, parameterized reset value), SHALL be instantiated once per register x1..x31.
REQ-029 Write-enable decode (one-hot from Write_Register_i gated by Reg_Write_i) and two read muxes SHALL live in register_file.

Verification
REQ-030 Reset: reset low at t=3 ns with no clk -> rs1=2 reads 7FFF_EFFC, rs2=3 reads 1000_8000, rs1=5 reads 0.
REQ-031 Write/read: Reg_Write_i=1, rd=5, data=DEAD_BEEF, one edge -> rs1=5 and rs2=5 read DEAD_BEEF.
REQ-032 x0: Reg_Write_i=1, rd=0, data=FFFF_FFFF -> rs1=0 reads 0 after the edge.
REQ-033 Same-cycle read/write: x7=1, write rd=7 data=2 with rs1=7 -> reads 1 before the edge, 2 after.
REQ-034 Enable low: Reg_Write_i=0, rd=9, data=1234_5678 over 3 edges -> x9 stays 0.
REQ-035 Sweep: write x1..x31 with index*0x0101_0101, reset low mid-sweep -> all except x2/x3 read 0 immediately.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths, ABI register indices and reset values for the RV32 datapath.
package register_file_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int ZERO = 0;
   localparam int RA   = 1;
   localparam int SP   = 2;
   localparam int GP   = 3;
   localparam logic [DATA_WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC;
   localparam logic [DATA_WIDTH-1:0] GP_INIT = 32'h1000_8000;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: write-back and dual read-port bundle between the pipeline and the register file.
interface register_file_if #(
   parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
);
   logic                  Reg_Write_i;
   logic [ADDR_WIDTH-1:0] Write_Register_i;
   logic [ADDR_WIDTH-1:0] Read_Register_1_i;
   logic [ADDR_WIDTH-1:0] Read_Register_2_i;
   logic [DATA_WIDTH-1:0] Write_Data_i;
   logic [DATA_WIDTH-1:0] Read_Data_1_o;
   logic [DATA_WIDTH-1:0] Read_Data_2_o;
   modport master (
      output Reg_Write_i, Write_Register_i, Read_Register_1_i, Read_Register_2_i, Write_Data_i,
      input  Read_Data_1_o, Read_Data_2_o
   );
   modport slave (
      input  Reg_Write_i, Write_Register_i, Read_Register_1_i, Read_Register_2_i, Write_Data_i,
      output Read_Data_1_o, Read_Data_2_o
   );
endinterface

// File: rtl/register_file_data_register.sv
// data_register: one architectural register with enable and a per-instance asynchronous reset value.
module data_register #(
   parameter int              WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_q <= RESET_VALUE;
      else if (i_en) r_q <= i_d;
   assign o_q = r_q;
endmodule

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH integer registers, x0 hardwired to zero,
// one synchronous write port and two combinational read ports without write-through.
module register_file #(
   parameter int                    DATA_WIDTH = register_file_pkg::DATA_WIDTH,
   parameter int                    ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = register_file_pkg::SP_INIT,
   parameter logic [DATA_WIDTH-1:0] GP_INIT    = register_file_pkg::GP_INIT
) (
   input logic             clk,
   input logic             reset,
   register_file_if.slave  bus
);
   import register_file_pkg::*;
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
   logic [NUM_REGS-1:1]   w_we;
   assign w_regs[ZERO] = '0;
   // x0 has no storage; each remaining index gets its own enable from the one-hot decode
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      assign w_we[g] = bus.Reg_Write_i & (bus.Write_Register_i == ADDR_WIDTH'(g));
      data_register #(
         .WIDTH       (DATA_WIDTH),
         .RESET_VALUE (g == SP ? SP_INIT : g == GP ? GP_INIT : {DATA_WIDTH{1'b0}})
      ) u_reg (
         .clk   (clk),
         .reset (reset),
         .i_en  (w_we[g]),
         .i_d   (bus.Write_Data_i),
         .o_q   (w_regs[g])
      );
   end
   assign bus.Read_Data_1_o = w_regs[bus.Read_Register_1_i];
   assign bus.Read_Data_2_o = w_regs[bus.Read_Register_2_i];
endmodule
